// File: rtl/stack_binop_pkg.sv
// Shared encodings for the stack execution stage: opcodes, stack interface, traps, FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package stack_binop_pkg;

    // Opcodes accepted on cmd_op
    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR_S = 4'd7,
        OP_SHR_U = 4'd8,
        OP_EQ    = 4'd9,
        OP_NE    = 4'd10,
        OP_LT_S  = 4'd11,
        OP_LT_U  = 4'd12,
        OP_DIV_U = 4'd13,
        OP_REM_U = 4'd14,
        OP_EQZ   = 4'd15
    } op_e;

    // Operation requested from the operand stack
    typedef enum logic [1:0] {
        STK_NONE    = 2'd0,
        STK_PUSH    = 2'd1,
        STK_POP     = 2'd2,
        STK_REPLACE = 2'd3
    } stk_op_e;

    // Status reported by the operand stack for its last operation
    typedef enum logic [1:0] {
        ST_NONE      = 2'd0,
        ST_EMPTY     = 2'd1,
        ST_OVERFLOW  = 2'd2,
        ST_UNDERFLOW = 2'd3
    } stk_status_e;

    // Sticky trap causes
    typedef enum logic [1:0] {
        TRAP_NONE      = 2'd0,
        TRAP_UNDERFLOW = 2'd1,
        TRAP_DIV0      = 2'd2
    } trap_e;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP_B  = 3'd1,
        S_POP_A  = 3'd2,
        S_PUSH_R = 3'd3,
        S_TRAP   = 3'd4
    } state_e;

    // Only EQZ consumes a single operand
    function automatic logic is_unary(input logic [3:0] op);
        return op == OP_EQZ;
    endfunction

endpackage

// File: rtl/stack_binop_alu.sv
// Combinational i32-style ALU: result = a OP b (unary ops use b only), flags unsigned divide by zero.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the sequencer samples the outputs when it needs them.
module stack_binop_alu
    import stack_binop_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    logic           b_zero;

    // Shift amounts wrap modulo WIDTH by using only the low bits of b
    assign shamt  = b[SHW-1:0];
    assign b_zero = (b == '0);

    // Result mux; divide results are forced to zero when b is zero so no X escapes
    always_comb begin
        result   = '0;
        div_zero = b_zero && (op == OP_DIV_U || op == OP_REM_U);
        case (op)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_MUL:   result = a * b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_SHL:   result = a << shamt;
            OP_SHR_S: result = $unsigned($signed(a) >>> shamt);
            OP_SHR_U: result = a >> shamt;
            OP_EQ:    result = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_NE:    result = {{(WIDTH-1){1'b0}}, (a != b)};
            OP_LT_S:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_LT_U:  result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_DIV_U: result = b_zero ? '0 : (a / b);
            OP_REM_U: result = b_zero ? '0 : (a % b);
            OP_EQZ:   result = {{(WIDTH-1){1'b0}}, b_zero};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/stack_binop.sv
// Execution stage on the operand stack: pops one or two operands, pushes a OP b, raises sticky traps.
// Latency: binary op = accept + 3 cycles to done (POP, POP, PUSH); unary op = accept + 2 cycles.
// Backpressure: cmd_ready is high only when idle; cmd_valid outside idle is dropped, not queued.
module stack_binop
    import stack_binop_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [3:0]       cmd_op,
    output logic             cmd_ready,
    output logic             done,
    output logic             trap,
    output logic [1:0]       trap_code,
    output logic [1:0]       stack_op,
    output logic [WIDTH-1:0] stack_data,
    input  logic [WIDTH-1:0] stack_tos,
    input  logic [1:0]       stack_status
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;
    logic [1:0]       trap_code_q, trap_code_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] alu_result;
    logic             alu_div_zero;
    logic             underflow;

    assign underflow = (stack_status == ST_UNDERFLOW);

    stack_binop_alu #(.WIDTH(WIDTH)) u_alu (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .result   (alu_result),
        .div_zero (alu_div_zero)
    );

    // State, operand capture and sticky trap code; reset aborts any sequence in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            trap_code_q <= TRAP_NONE;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            trap_code_q <= trap_code_d;
            done_q      <= done_d;
            if (state_q == S_IDLE && cmd_valid)
                op_q <= cmd_op;
            if (state_q == S_POP_B)
                b_q <= stack_tos;
            if (state_q == S_POP_A && !underflow)
                a_q <= stack_tos;
        end
    end

    // Next state and stack commands; the stack status reflects the previous cycle's pop
    always_comb begin
        state_d     = state_q;
        trap_code_d = trap_code_q;
        done_d      = 1'b0;
        stack_op    = STK_NONE;
        stack_data  = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid)
                    state_d = S_POP_B;
            end
            S_POP_B: begin
                stack_op = STK_POP;
                state_d  = is_unary(op_q) ? S_PUSH_R : S_POP_A;
            end
            S_POP_A: begin
                if (underflow) begin
                    state_d     = S_TRAP;
                    trap_code_d = TRAP_UNDERFLOW;
                end else begin
                    stack_op = STK_POP;
                    state_d  = S_PUSH_R;
                end
            end
            S_PUSH_R: begin
                if (underflow) begin
                    state_d     = S_TRAP;
                    trap_code_d = TRAP_UNDERFLOW;
                end else if (alu_div_zero) begin
                    state_d     = S_TRAP;
                    trap_code_d = TRAP_DIV0;
                end else begin
                    stack_op   = STK_PUSH;
                    stack_data = alu_result;
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign done      = done_q;
    assign trap      = (state_q == S_TRAP);
    assign trap_code = trap_code_q;

endmodule

// File: tb/tb_stack_binop.sv
// Randomised scoreboard bench for stack_binop with a behavioural operand stack and reference model.
// Latency: checks done arrives 3 cycles (binary) / 2 cycles (unary) after accept.
// Backpressure: issues commands only while cmd_ready is high.
module tb_stack_binop;
    import stack_binop_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 16;

    typedef struct {
        logic         is_trap;
        logic [1:0]   code;
        logic [W-1:0] val;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic [3:0]   cmd_op;
    logic         cmd_ready, done, trap;
    logic [1:0]   trap_code, stack_op, stack_status;
    logic [W-1:0] stack_data, stack_tos;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    exp_t         sbq[$];
    logic [W-1:0] rstk[$];

    stack_binop #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_ready    (cmd_ready),
        .done         (done),
        .trap         (trap),
        .trap_code    (trap_code),
        .stack_op     (stack_op),
        .stack_data   (stack_data),
        .stack_tos    (stack_tos),
        .stack_status (stack_status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural operand stack that the DUT talks to; the bench preloads it through tb_push
    logic [W-1:0] mem [DEPTH];
    logic [4:0]   cnt;
    logic [3:0]   top_idx;
    logic         tb_push;
    logic [W-1:0] tb_push_dat;

    assign top_idx   = 4'(cnt - 5'd1);
    assign stack_tos = (cnt != 5'd0) ? mem[top_idx] : '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= 5'd0;
            stack_status <= ST_NONE;
        end else if (tb_push) begin
            mem[cnt[3:0]] <= tb_push_dat;
            cnt           <= cnt + 5'd1;
            stack_status  <= ST_NONE;
        end else begin
            case (stack_op)
                STK_PUSH: begin
                    mem[cnt[3:0]] <= stack_data;
                    cnt           <= cnt + 5'd1;
                    stack_status  <= ST_NONE;
                end
                STK_POP: begin
                    if (cnt == 5'd0) begin
                        stack_status <= ST_UNDERFLOW;
                    end else begin
                        cnt          <= cnt - 5'd1;
                        stack_status <= (cnt == 5'd1) ? ST_EMPTY : ST_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: WebAssembly-style i32 semantics on W-bit values, computed with integers
    function automatic exp_t predict(input logic [3:0] op);
        exp_t e;
        int   a, b, sa, sb, r, n;
        e.is_trap = 1'b0;
        e.code    = 2'd0;
        e.val     = '0;
        e.due     = 0;
        n = (op == OP_EQZ) ? 1 : 2;
        if (rstk.size() < n) begin
            e.is_trap = 1'b1;
            e.code    = 2'd1;
            rstk.delete();
            return e;
        end
        b = int'(rstk.pop_back());
        a = (n == 2) ? int'(rstk.pop_back()) : 0;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        if ((op == OP_DIV_U || op == OP_REM_U) && b == 0) begin
            e.is_trap = 1'b1;
            e.code    = 2'd2;
            return e;
        end
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_MUL:   r = a * b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_SHL:   r = a << (b % W);
            OP_SHR_S: r = sa >>> (b % W);
            OP_SHR_U: r = a >> (b % W);
            OP_EQ:    r = (a == b) ? 1 : 0;
            OP_NE:    r = (a != b) ? 1 : 0;
            OP_LT_S:  r = (sa < sb) ? 1 : 0;
            OP_LT_U:  r = (a < b) ? 1 : 0;
            OP_DIV_U: r = a / b;
            OP_REM_U: r = a % b;
            default:  r = (b == 0) ? 1 : 0;
        endcase
        e.val = r[W-1:0];
        rstk.push_back(e.val);
        return e;
    endfunction

    // All driver tasks start and end just after a falling edge
    task automatic push_val(input logic [W-1:0] v);
        tb_push     = 1'b1;
        tb_push_dat = v;
        rstk.push_back(v);
        @(negedge clk);
        tb_push = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_trap", {31'd0, trap}, 0);
        chk("rst_trap_code", {30'd0, trap_code}, 0);
        chk("rst_stack_op", {30'd0, stack_op}, STK_NONE);
        chk("rst_stack_data", {24'd0, stack_data}, 0);
        @(negedge clk);
        reset = 1'b0;
        rstk.delete();
        sbq.delete();
    endtask

    task automatic issue(input logic [3:0] op, output logic trapped);
        exp_t e;
        int   n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 1);
        e     = predict(op);
        e.due = cyc + ((op == OP_EQZ) ? 3 : 4);
        sbq.push_back(e);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = $urandom_range(0, 15);
        n = 0;
        while (!(done || trap) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("op_completes", {31'd0, (done | trap)}, 1);
        trapped = trap;
    endtask

    // Monitor: pops the scoreboard on done or on the first cycle of a trap
    initial begin
        exp_t e;
        logic trap_seen;
        trap_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                trap_seen = 1'b0;
            end else begin
                if (stack_op == STK_PUSH) begin
                    if (sbq.size() == 0 || sbq[0].is_trap)
                        chk("no_push_expected", {30'd0, stack_op}, STK_NONE);
                    else
                        chk("push_data", {24'd0, stack_data}, {24'd0, sbq[0].val});
                end
                if (done) begin
                    if (sbq.size() == 0) begin
                        chk("spurious_done", {31'd0, done}, 0);
                    end else begin
                        e = sbq.pop_front();
                        if (e.is_trap) begin
                            chk("done_but_trap_expected", {31'd0, done}, 0);
                        end else begin
                            chk("tos_after_done", {24'd0, stack_tos}, {24'd0, e.val});
                            chk("done_latency", cyc, e.due);
                        end
                    end
                end
                if (trap && !trap_seen) begin
                    trap_seen = 1'b1;
                    if (sbq.size() == 0) begin
                        chk("spurious_trap", {31'd0, trap}, 0);
                    end else begin
                        e = sbq.pop_front();
                        if (!e.is_trap)
                            chk("unexpected_trap", {31'd0, trap}, 0);
                        else
                            chk("trap_code", {30'd0, trap_code}, {30'd0, e.code});
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        logic         tr;
        logic [3:0]   op;
        logic [W-1:0] v;
        int           np;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 4'd0;
        tb_push     = 1'b0;
        tb_push_dat = '0;
        @(negedge clk);
        do_reset();

        // Directed cases
        push_val(8'd7);  push_val(8'd5);  issue(OP_SUB, tr);
        push_val(8'hF0); push_val(8'h09); issue(OP_SHL, tr);
        push_val(8'h02); issue(OP_SHR_S, tr);
        push_val(8'h80); push_val(8'h01); issue(OP_LT_S, tr);
        push_val(8'h80); push_val(8'h01); issue(OP_LT_U, tr);
        push_val(8'h00); issue(OP_EQZ, tr);
        do_reset();
        issue(OP_ADD, tr);
        chk("underflow_trap_holds_ready", {31'd0, cmd_ready}, 0);
        @(negedge clk);
        chk("underflow_trap_sticky", {31'd0, trap}, 1);
        do_reset();
        push_val(8'd9); push_val(8'd0); issue(OP_DIV_U, tr);
        do_reset();

        // Reset while the second pop is being driven
        push_val(8'd3); push_val(8'd4);
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pop_a_drives_pop", {30'd0, stack_op}, STK_POP);
        do_reset();

        // Random ops over random stack contents
        for (int i = 0; i < 300; i++) begin
            np = (rstk.size() < 12) ? $urandom_range(0, 2) : 0;
            for (int k = 0; k < np; k++) begin
                v = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                push_val(v);
            end
            op = 4'($urandom_range(0, 15));
            issue(op, tr);
            if (tr) do_reset();
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_binop.md
Name: stack_binop

Overview:
- Execution stage that sits directly downstream of the operand stack and consumes its top-of-stack.
- Accepts one arithmetic/logic/compare opcode per handshake and pops its operands off the stack (one for unary, two for binary).
- Computes the result and pushes it back, matching WebAssembly i32 numeric semantics.
- Signals completion with `done`. Stack underflow and division by zero raise a sticky trap.

Parameters:
- WIDTH, 32, operand/result width in bits; must equal the stack's WIDTH and be a power of two.
- SHW, $clog2(WIDTH), shift-amount bits; derived, not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  opcode offered
- cmd_op  in  4  opcode (encodings in package)
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready at posedge
- done  out  1  one-cycle pulse: result pushed
- trap  out  1  sticky until reset
- trap_code  out  2  0 none, 1 stack underflow, 2 divide by zero
- stack_op  out  2  to stack op port (NONE/PUSH/POP/REPLACE from stack.vh)
- stack_data  out  WIDTH  to stack data port
- stack_tos  in  WIDTH  stack top-of-stack
- stack_status  in  2  stack status (NONE/EMPTY/OVERFLOW/UNDERFLOW)

Behaviour:
- Reset values (async):
  - state = IDLE; a, b, op registers = 0.
  - cmd_ready = 1; done = 0; trap = 0; trap_code = 0; stack_op = NONE; stack_data = 0.
  - Reset mid-sequence aborts with no further stack ops.
- stack_op and stack_data are decoded from state and registers only; they do not depend combinationally on cmd_*.
- Operand order: b is the top of stack, a is the element below it. Result = a OP b. Unary ops use b only.
- IDLE:
  - On accept, latch cmd_op and go to POP_B.
  - done is driven low here except the single cycle after PUSH_R.
- POP_B:
  - Drive stack_op = POP and latch b <= stack_tos.
  - Next state is PUSH_R if the op is unary (EQZ), otherwise POP_A.
- POP_A:
  - If stack_status == UNDERFLOW, go to TRAP with code 1 and drive stack_op = NONE.
  - Otherwise drive POP, latch a <= stack_tos, and go to PUSH_R.
- PUSH_R:
  - If stack_status == UNDERFLOW, go to TRAP with code 1.
  - Else if op is DIV_U/REM_U and b == 0, go to TRAP with code 2 and do not push.
  - Otherwise drive stack_op = PUSH and stack_data = result, then go to IDLE with done = 1 for exactly one cycle.
- TRAP:
  - cmd_ready = 0, stack_op = NONE, trap = 1, trap_code held.
  - Left only by reset. Stack contents after a trap are unspecified.
- Latency (binary): accept at edge E0; POP at E1, POP at E2, PUSH at E3; done high from E3 to E4. Unary ops take one cycle less.
- Arithmetic:
  - Modulo 2^WIDTH; no overflow detection.
  - Shifts use b[SHW-1:0] only, so the amount wraps modulo WIDTH.
  - SHR_S is arithmetic.
  - Compares and EQZ return 1 or 0, zero-extended.
  - LT_S is signed, LT_U unsigned.
  - DIV_U/REM_U are unsigned and combinational.
- Stack OVERFLOW is unreachable, because the push always follows at least one pop, and is ignored.
- cmd_valid asserted outside IDLE is ignored and not queued.

Decomposition:
- Add to stack.vh, or a sibling binop.vh:
  - opcode defines: ADD 0, SUB 1, MUL 2, AND 3, OR 4, XOR 5, SHL 6, SHR_S 7, SHR_U 8, EQ 9, NE 10, LT_S 11, LT_U 12, DIV_U 13, REM_U 14, EQZ 15;
  - trap code defines;
  - FSM state encodings.
- One natural sub-module: binop_alu, purely combinational (a, b, op -> result, div_zero). The FSM stays in stack_binop.

Test Plan (WIDTH=8, stack DEPTH giving ≥4 entries, shared clk/reset):
- Push 7, push 5; issue SUB -> cmd_ready drops for 3 cycles, done pulses once, tos = 8'h02, status NONE.
- Push 8'hF0, push 8'h09; issue SHL -> shift amount 9 mod 8 = 1, tos = 8'hE0. Then issue SHR_S with 2 pushed -> tos = 8'hF8.
- Push 8'h80, push 8'h01; LT_S -> tos = 8'h01. Repeat with LT_U -> tos = 8'h00.
- Push 0; EQZ -> tos = 8'h01 and done after 2 stack cycles (POP then PUSH, no second POP).
- Empty stack; ADD -> after POP_B, UNDERFLOW seen -> trap = 1, trap_code = 1, no PUSH issued, cmd_ready stays 0. Assert reset -> trap = 0, cmd_ready = 1.
- Push 9, push 0; DIV_U -> trap_code = 2, done never pulses. Assert reset while in POP_A of a fresh ADD -> stack_op = NONE immediately, state IDLE.
